mdu_seq: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit for the MIPS pipeline's EX stage.
- It is the sequential successor to the 1-bit ALU slice. It handles MULT/MULTU/DIV/DIVU with one bit of work per clock, plus MTHI/MTLO, and holds results in architectural HI/LO registers.
- The pipeline stalls on busy and reads HI/LO (MFHI/MFLO) once done.

---
 rtl/mdu_seq_if.sv | 26 ++
 rtl/mdu_seq.sv | 154 +++++++++++++++
 tb/tb_mdu_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the
// sequential multiply/divide unit (slave).
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with MTHI/MTLO: one bit per clock on
// unsigned magnitudes, sign fix-up in a final cycle, results held in HI/LO.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sa;
    logic               sb;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               dz;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // Sign flags only matter for the signed opcodes (op[0]=1).
    assign sa = bus.op[0] & bus.a[WIDTH-1];
    assign sb = bus.op[0] & bus.b[WIDTH-1];

    // Negating the most-negative value returns it unchanged, which is exactly
    // its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? -v : v;
    endfunction

    // acc holds {partial product} for multiply, {remainder, quotient/dividend}
    // for divide; both shift one bit per CALC cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        step    = acc;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        if (is_div) begin
            if (diff[WIDTH]) step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else             step = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
        end else begin
            step = {psum, acc[WIDTH-1:1]};
        end

        prod   = neg_q ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        dz     = is_div && (opnd == '0);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_r ? -rem : rem;
            fix_lo = dz ? '1 : (neg_q ? -quo : quo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (!bus.op[2]) begin
                            is_div <= bus.op[1];
                            neg_q  <= sa ^ sb;
                            neg_r  <= sa;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= CALC;
                            if (bus.op[1]) begin
                                opnd <= magnitude(bus.b, sb);
                                acc  <= {{WIDTH{1'b0}}, magnitude(bus.a, sa)};
                            end else begin
                                opnd <= magnitude(bus.a, sa);
                                acc  <= {{WIDTH{1'b0}}, magnitude(bus.b, sb)};
                            end
                        end else if (bus.op == OP_MTHI) begin
                            hi_q   <= bus.a;
                            done_q <= 1'b1;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q   <= bus.a;
                            done_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc <= step;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        dz_q   <= dz;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random ops on a
// 32-bit and an 8-bit instance, compared against an arithmetic reference.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) b32 ();
    mdu_seq_if #(.WIDTH(8))  b8 ();

    mdu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    mdu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y, input logic f);
        if (w == 32) begin
            b32.start = s; b32.op = o; b32.a = x; b32.b = y; b32.flush = f;
        end else begin
            b8.start = s; b8.op = o; b8.a = x[7:0]; b8.b = y[7:0]; b8.flush = f;
        end
    endtask

    function automatic logic [31:0] get_hi(input int w);
        return (w == 32) ? b32.hi : {24'b0, b8.hi};
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 32) ? b32.lo : {24'b0, b8.lo};
    endfunction
    function automatic logic get_done(input int w);
        return (w == 32) ? b32.done : b8.done;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 32) ? b32.busy : b8.busy;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 32) ? b32.div_zero : b8.div_zero;
    endfunction

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint mask;
        longint va;
        longint vb;
        logic [63:0] p;
        mask = (longint'(1) << w) - 1;
        va = longint'(a) & mask;
        vb = longint'(b) & mask;
        if (op[0] && va[w-1]) va = va - (longint'(1) << w);
        if (op[0] && vb[w-1]) vb = vb - (longint'(1) << w);
        if (!op[1]) begin
            p  = va * vb;
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (vb == 0) begin
            hi = 32'(longint'(a) & mask);
            lo = 32'(mask);
        end else begin
            hi = 32'((va % vb) & mask);
            lo = 32'((va / vb) & mask);
        end
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom % 6)
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = (w == 32) ? 32'h8000_0000 : 32'h80;
            4: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return (w == 32) ? v : (v & 32'hFF);
    endfunction

    // Issues one op and returns at the negedge where done is seen.
    task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit chain, input bit poke);
        int k;
        int lat;
        int bcnt;
        logic [31:0] m;
        logic [31:0] eh;
        logic [31:0] el;
        bit md;
        k  = (w == 32) ? 0 : 1;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'hFF;
        md = !op[2];
        if (op == 3'b100)      begin eh = a & m;     el = exp_lo[k]; end
        else if (op == 3'b101) begin eh = exp_hi[k]; el = a & m;     end
        else model(w, op, a, b, eh, el);
        if (!chain) @(negedge clk);
        drive(w, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, op, a, b, 1'b0);
        lat = 0;
        bcnt = 0;
        while (!get_done(w) && lat < 4 * w) begin
            if (get_busy(w)) bcnt++;
            if (poke && lat == 3) drive(w, 1'b1, 3'b100, $urandom, b, 1'b0);
            if (poke && lat == 4) drive(w, 1'b0, op, a, b, 1'b0);
            @(negedge clk);
            lat++;
        end
        check("done_seen", get_done(w), 1);
        check("latency", lat, md ? w + 1 : 0);
        check("busy_cycles", bcnt, md ? w + 1 : 0);
        check("busy_at_done", get_busy(w), 0);
        check("hi", get_hi(w), eh);
        check("lo", get_lo(w), el);
        check("div_zero", get_dz(w), md && op[1] && ((b & m) == 0));
        exp_hi[k] = eh;
        exp_lo[k] = el;
    endtask

    task automatic quiet(input int w);
        int k;
        k = (w == 32) ? 0 : 1;
        @(negedge clk);
        check("done_single", get_done(w), 0);
        check("hi_hold", get_hi(w), exp_hi[k]);
        check("lo_hold", get_lo(w), exp_lo[k]);
    endtask

    initial begin
        int ndone;
        drive(32, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        drive(8, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        #12;
        check("rst_busy", b32.busy, 0);
        check("rst_done", b32.done, 0);
        check("rst_dz", b32.div_zero, 0);
        check("rst_hilo", {b32.hi, b32.lo}, 64'd0);
        check("rst8_hilo", {b8.hi, b8.lo}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max", {b32.hi, b32.lo}, 64'hFFFF_FFFE_0000_0001);
        quiet(32);
        do_op(32, 3'b001, 32'hFFFF_FFF9, 32'd3, 0, 0);
        check("mult_neg", {b32.hi, b32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(32, 3'b011, 32'hFFFF_FFF9, 32'd2, 1, 0);
        check("div_neg", {b32.hi, b32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(32, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
        check("div_ovf", {b32.hi, b32.lo}, 64'h0000_0000_8000_0000);
        quiet(32);
        do_op(32, 3'b010, 32'd100, 32'd0, 0, 0);
        check("divu_zero", {b32.hi, b32.lo}, 64'h0000_0064_FFFF_FFFF);
        do_op(32, 3'b010, 32'd100, 32'd7, 1, 0);
        check("divu_100_7", {b32.hi, b32.lo}, 64'h0000_0002_0000_000E);
        quiet(32);
        do_op(32, 3'b100, 32'h1234_5678, 32'd0, 0, 0);
        do_op(32, 3'b101, 32'h0000_CAFE, 32'd0, 0, 0);
        check("mthi_mtlo", {b32.hi, b32.lo}, 64'h1234_5678_0000_CAFE);
        quiet(32);

        // Flush a MULTU mid-way: no done, HI/LO untouched.
        @(negedge clk);
        drive(32, 1'b1, 3'b000, 32'd12345, 32'd678, 1'b0);
        @(negedge clk);
        drive(32, 1'b0, 3'b000, 32'd12345, 32'd678, 1'b0);
        repeat (9) @(negedge clk);
        drive(32, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        drive(32, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        check("flush_busy", b32.busy, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b32.done) ndone++;
        end
        check("flush_no_done", ndone, 0);
        check("flush_hilo", {b32.hi, b32.lo}, {exp_hi[0], exp_lo[0]});

        // Flush wins over a simultaneous start in IDLE; reserved ops ignored.
        drive(32, 1'b1, 3'b100, 32'hDEAD_BEEF, 32'd0, 1'b1);
        @(negedge clk);
        drive(32, 1'b1, 3'b110, 32'hDEAD_BEEF, 32'd1, 1'b0);
        check("idle_flush_done", b32.done, 0);
        check("idle_flush_hi", b32.hi, exp_hi[0]);
        @(negedge clk);
        drive(32, 1'b1, 3'b111, 32'hDEAD_BEEF, 32'd1, 1'b0);
        check("rsvd110_done", b32.done, 0);
        check("rsvd110_busy", b32.busy, 0);
        @(negedge clk);
        drive(32, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        check("rsvd111_done", b32.done, 0);
        check("rsvd111_busy", b32.busy, 0);
        check("rsvd_hilo", {b32.hi, b32.lo}, {exp_hi[0], exp_lo[0]});

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        drive(32, 1'b1, 3'b011, 32'hFFFF_FF00, 32'd5, 1'b0);
        @(negedge clk);
        drive(32, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", b32.busy, 0);
        check("arst_done", b32.done, 0);
        check("arst_dz", b32.div_zero, 0);
        check("arst_hilo", {b32.hi, b32.lo}, 64'd0);
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32, 3'b000, 32'd6, 32'd7, 0, 0);
        check("multu_6_7", {b32.hi, b32.lo}, 64'd42);

        do_op(8, 3'b001, 32'h80, 32'h80, 0, 0);
        check("w8_mult", {b8.hi, b8.lo}, 16'h4000);
        do_op(8, 3'b011, 32'h80, 32'hFF, 1, 0);
        check("w8_div_ovf", {b8.hi, b8.lo}, 16'h0080);
        do_op(8, 3'b011, 32'hF9, 32'd0, 1, 0);
        check("w8_div_zero", {b8.hi, b8.lo}, 16'hF9FF);
        quiet(8);

        for (int i = 0; i < 40; i++) begin
            do_op(32, 3'($urandom_range(0, 5)), pick(32), pick(32),
                  bit'($urandom % 2), bit'($urandom % 2));
            if ($urandom % 3 == 0) quiet(32);
        end
        for (int i = 0; i < 30; i++) begin
            do_op(8, 3'($urandom_range(0, 5)), pick(8), pick(8),
                  bit'($urandom % 2), bit'($urandom % 2));
            if ($urandom % 3 == 0) quiet(8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
